// File: rtl/sd_arb_pkg.sv
// Shared types and widths for the two-drive SD sector arbiter.
// Pure declarations: no latency, no flow control.
package sd_arb_pkg;
    localparam int NREQ   = 2;
    localparam int LBA_W  = 32;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    function automatic logic [NREQ-1:0] sel_mask(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/sd_drive_arbiter_if.sv
// hps_io SD sector bus; master = arbiter side, slave = hps_io side.
// Wires only: no latency, sd_ack is the sole handshake back to the arbiter.
interface sd_drive_arbiter_if;
    import sd_arb_pkg::*;

    logic [LBA_W-1:0]  sd_lba;
    logic [NREQ-1:0]   sd_rd;
    logic [NREQ-1:0]   sd_wr;
    logic              sd_ack;
    logic [ADDR_W-1:0] sd_buff_addr;
    logic [DATA_W-1:0] sd_buff_dout;
    logic [DATA_W-1:0] sd_buff_din;
    logic              sd_buff_wr;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_arb_rr.sv
// Two-way round-robin picker: on a tie the drive not served last wins.
// Combinational, zero latency, no flow control.
module sd_arb_rr
    import sd_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_pending,
    input  logic            i_last_grant,
    output logic            o_grant,
    output logic            o_valid
);
    assign o_valid = |i_pending;

    always_comb begin
        if (&i_pending) o_grant = ~i_last_grant;
        else            o_grant = i_pending[1];
    end
endmodule

// File: rtl/sd_drive_arbiter.sv
// Shares one hps_io SD sector port between two floppy drives, one sector at a time; request edge -> sd_rd/sd_wr in 2 cycles, ack fall -> req_done in 1.
// Stalls in REQ until sd_ack (bounded by TIMEOUT_CYCLES when SD_ARB_TIMEOUT_EN is defined); never grants while sd_ack is high.
module sd_drive_arbiter #(
    parameter int          NREQ           = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16000000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [2*32-1:0]     req_lba,
    input  logic [NREQ-1:0]     req_rd,
    input  logic [NREQ-1:0]     req_wr,
    output logic [NREQ-1:0]     req_busy,
    output logic [NREQ-1:0]     req_done,
    output logic [NREQ-1:0]     req_err,
    output logic [8:0]          req_buff_addr,
    output logic [7:0]          req_buff_dout,
    input  logic [15:0]         req_buff_din,
    output logic [NREQ-1:0]     req_buff_wr,
    input  logic [NREQ-1:0]     img_mounted,
    sd_drive_arbiter_if.master  sd
);
    import sd_arb_pkg::*;

    state_t           r_state, w_state_nxt;
    logic [NREQ-1:0]  r_req_rd_d, r_req_wr_d, r_pend_rd, r_pend_wr;
    logic [NREQ-1:0]  r_sd_rd, r_sd_wr;
    logic [LBA_W-1:0] r_sd_lba;
    logic             r_g, r_last_grant;
    logic             w_rr_grant, w_rr_vld, w_grant_ld, w_finish, w_timeout, w_active;
    logic [NREQ-1:0]  w_rise_rd, w_rise_wr, w_mount_clr, w_pend_arb, w_gmask;

    assign req_busy    = r_pend_rd | r_pend_wr;
    assign w_active    = (r_state == REQ) || (r_state == XFER);
    assign w_gmask     = sel_mask(r_g);
    assign w_rise_rd   = req_rd & ~r_req_rd_d;
    assign w_rise_wr   = req_wr & ~r_req_wr_d;
    // A mount cannot abort the transaction already on the bus.
    assign w_mount_clr = img_mounted & ~(w_active ? w_gmask : '0);
    assign w_pend_arb  = req_busy & ~img_mounted;

    sd_arb_rr u_rr (
        .i_pending    (w_pend_arb),
        .i_last_grant (r_last_grant),
        .o_grant      (w_rr_grant),
        .o_valid      (w_rr_vld)
    );

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] r_to_cnt;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)              r_to_cnt <= '0;
        else if (w_grant_ld)       r_to_cnt <= '0;
        else if (r_state == REQ)   r_to_cnt <= r_to_cnt + 24'd1;
    end
    assign w_timeout = (r_state == REQ) && (r_to_cnt == TIMEOUT_CYCLES - 24'd1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_ld  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: if (w_rr_vld && !sd.sd_ack) begin
                w_grant_ld  = 1'b1;
                w_state_nxt = REQ;
            end
            REQ: begin
                if (w_timeout) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (sd.sd_ack) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: if (!sd.sd_ack) w_state_nxt = DONE;
            DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_req_rd_d   <= '0;
            r_req_wr_d   <= '0;
            r_pend_rd    <= '0;
            r_pend_wr    <= '0;
            r_sd_rd      <= '0;
            r_sd_wr      <= '0;
            r_sd_lba     <= '0;
            r_g          <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_req_rd_d <= req_rd;
            r_req_wr_d <= req_wr;
            for (int i = 0; i < NREQ; i++) begin
                if (w_mount_clr[i] || (w_finish && w_gmask[i])) begin
                    r_pend_rd[i] <= 1'b0;
                    r_pend_wr[i] <= 1'b0;
                end else if (!req_busy[i]) begin
                    if (w_rise_rd[i])      r_pend_rd[i] <= 1'b1;
                    else if (w_rise_wr[i]) r_pend_wr[i] <= 1'b1;
                end
            end
            if (w_grant_ld) begin
                r_g      <= w_rr_grant;
                r_sd_lba <= w_rr_grant ? req_lba[2*LBA_W-1:LBA_W] : req_lba[LBA_W-1:0];
                r_sd_rd  <= r_pend_rd[w_rr_grant] ? sel_mask(w_rr_grant) : '0;
                r_sd_wr  <= r_pend_wr[w_rr_grant] ? sel_mask(w_rr_grant) : '0;
            end else if (w_state_nxt != REQ) begin
                r_sd_rd <= '0;
                r_sd_wr <= '0;
            end
            if (w_finish) r_last_grant <= r_g;
        end
    end

    assign req_done       = w_finish  ? w_gmask : '0;
    assign req_err        = w_timeout ? w_gmask : '0;
    assign req_buff_addr  = sd.sd_buff_addr;
    assign req_buff_dout  = sd.sd_buff_dout;
    assign req_buff_wr    = (sd.sd_buff_wr && sd.sd_ack && w_active) ? w_gmask : '0;
    assign sd.sd_buff_din = !w_active ? '0 : (r_g ? req_buff_din[15:8] : req_buff_din[7:0]);
    assign sd.sd_lba      = r_sd_lba;
    assign sd.sd_rd       = r_sd_rd;
    assign sd.sd_wr       = r_sd_wr;
endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Directed bench for sd_drive_arbiter; the timeout scenario runs only when SD_ARB_TIMEOUT_EN is defined.
module tb_sd_drive_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] req_lba = '0;
    logic [1:0]  req_rd = '0, req_wr = '0, img_mounted = '0;
    logic [1:0]  req_busy, req_done, req_err, req_buff_wr;
    logic [8:0]  req_buff_addr;
    logic [7:0]  req_buff_dout;
    logic [15:0] req_buff_din = '0;
    int          errors = 0;
    int          checks = 0;

    sd_drive_arbiter_if sdif();

    sd_drive_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(24'd100)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .req_lba       (req_lba),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_busy      (req_busy),
        .req_done      (req_done),
        .req_err       (req_err),
        .req_buff_addr (req_buff_addr),
        .req_buff_dout (req_buff_dout),
        .req_buff_din  (req_buff_din),
        .req_buff_wr   (req_buff_wr),
        .img_mounted   (img_mounted),
        .sd            (sdif)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic run_xfer(output logic [1:0] o_rd, output logic [1:0] o_wr,
                            output logic [31:0] o_lba, output logic [1:0] o_done);
        for (int n = 0; n < 10 && (sdif.sd_rd | sdif.sd_wr) == 2'b00; n++) tick();
        o_rd  = sdif.sd_rd;
        o_wr  = sdif.sd_wr;
        o_lba = sdif.sd_lba;
        sdif.sd_ack = 1'b1;
        tick();
        tick();
        sdif.sd_ack = 1'b0;
        tick();
        o_done = req_done;
        tick();
    endtask

    task automatic test_reset();
        sdif.sd_ack = 1'b0; sdif.sd_buff_wr = 1'b0; sdif.sd_buff_addr = '0; sdif.sd_buff_dout = '0;
        do_reset();
        checks++; if (sdif.sd_rd !== 2'b00) begin errors++; $display("FAIL reset_sd_rd: got %b want 00", sdif.sd_rd); end
        checks++; if (sdif.sd_wr !== 2'b00) begin errors++; $display("FAIL reset_sd_wr: got %b want 00", sdif.sd_wr); end
        checks++; if (sdif.sd_lba !== 32'h0) begin errors++; $display("FAIL reset_sd_lba: got %h want 0", sdif.sd_lba); end
        checks++; if (req_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", req_busy); end
        checks++; if (req_done !== 2'b00 || req_err !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b/%b want 00/00", req_done, req_err); end
        checks++; if (sdif.sd_buff_din !== 8'h00) begin errors++; $display("FAIL reset_buff_din: got %h want 00", sdif.sd_buff_din); end
    endtask

    task automatic test_read();
        logic bw;
        req_lba = {32'h0, 32'h10};
        req_rd  = 2'b01;
        tick();
        checks++; if (req_busy !== 2'b01) begin errors++; $display("FAIL rd_busy: got %b want 01", req_busy); end
        checks++; if (sdif.sd_rd !== 2'b00) begin errors++; $display("FAIL rd_early: got %b want 00", sdif.sd_rd); end
        tick();
        checks++; if (sdif.sd_rd !== 2'b01) begin errors++; $display("FAIL rd_sd_rd: got %b want 01", sdif.sd_rd); end
        checks++; if (sdif.sd_lba !== 32'h10) begin errors++; $display("FAIL rd_lba: got %h want 10", sdif.sd_lba); end
        checks++; if (sdif.sd_wr !== 2'b00) begin errors++; $display("FAIL rd_sd_wr: got %b want 00", sdif.sd_wr); end
        sdif.sd_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bw = (i % 2 == 0);
            sdif.sd_buff_wr = bw;
            #1;
            checks++; if (req_buff_wr !== (bw ? 2'b01 : 2'b00)) begin errors++; $display("FAIL rd_buff_wr%0d: got %b want %b", i, req_buff_wr, bw ? 2'b01 : 2'b00); end
            tick();
        end
        checks++; if (sdif.sd_rd !== 2'b00) begin errors++; $display("FAIL rd_drop: got %b want 00", sdif.sd_rd); end
        sdif.sd_ack = 1'b0; sdif.sd_buff_wr = 1'b0;
        tick();
        checks++; if (req_done !== 2'b01 || req_err !== 2'b00) begin errors++; $display("FAIL rd_done: got %b/%b want 01/00", req_done, req_err); end
        tick();
        checks++; if (req_done !== 2'b00 || req_busy !== 2'b00) begin errors++; $display("FAIL rd_after: done %b busy %b want 00/00", req_done, req_busy); end
        req_rd = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] rd, wr, dn;
        logic [31:0] lba;
        do_reset();
        req_lba = {32'h200, 32'h100};
        req_wr = 2'b11; tick(); req_wr = 2'b00;
        run_xfer(rd, wr, lba, dn);
        checks++; if (wr !== 2'b01 || rd !== 2'b00 || lba !== 32'h100 || dn !== 2'b01) begin errors++; $display("FAIL rr_first: wr %b rd %b lba %h done %b want 01/00/100/01", wr, rd, lba, dn); end
        run_xfer(rd, wr, lba, dn);
        checks++; if (wr !== 2'b10 || lba !== 32'h200 || dn !== 2'b10) begin errors++; $display("FAIL rr_second: wr %b lba %h done %b want 10/200/10", wr, lba, dn); end
        req_wr = 2'b01; tick(); req_wr = 2'b00;
        run_xfer(rd, wr, lba, dn);
        checks++; if (wr !== 2'b01 || dn !== 2'b01) begin errors++; $display("FAIL rr_single: wr %b done %b want 01/01", wr, dn); end
        req_wr = 2'b11; tick(); req_wr = 2'b00;
        run_xfer(rd, wr, lba, dn);
        checks++; if (wr !== 2'b10 || lba !== 32'h200) begin errors++; $display("FAIL rr_tie_d1: wr %b lba %h want 10/200", wr, lba); end
        run_xfer(rd, wr, lba, dn);
        checks++; if (wr !== 2'b01 || lba !== 32'h100) begin errors++; $display("FAIL rr_tie_d0: wr %b lba %h want 01/100", wr, lba); end
    endtask

    task automatic test_steer();
        req_buff_din = {8'hA5, 8'h3C};
        req_wr = 2'b10; tick(); req_wr = 2'b00;
        for (int n = 0; n < 10 && sdif.sd_wr == 2'b00; n++) tick();
        checks++; if (sdif.sd_wr !== 2'b10) begin errors++; $display("FAIL st_grant: got %b want 10", sdif.sd_wr); end
        checks++; if (sdif.sd_buff_din !== 8'hA5) begin errors++; $display("FAIL st_din_req: got %h want a5", sdif.sd_buff_din); end
        sdif.sd_ack = 1'b1; tick();
        sdif.sd_buff_wr = 1'b1; #1;
        checks++; if (sdif.sd_buff_din !== 8'hA5) begin errors++; $display("FAIL st_din_xfer: got %h want a5", sdif.sd_buff_din); end
        checks++; if (req_buff_wr !== 2'b10) begin errors++; $display("FAIL st_buff_wr: got %b want 10", req_buff_wr); end
        sdif.sd_ack = 1'b0; sdif.sd_buff_wr = 1'b0;
        tick();
        checks++; if (sdif.sd_buff_din !== 8'h00 || req_done !== 2'b10) begin errors++; $display("FAIL st_done: din %h done %b want 00/10", sdif.sd_buff_din, req_done); end
        tick();
    endtask

    task automatic test_stale_ack();
        logic [1:0] seen_rd, seen_bw;
        req_rd = 2'b01; tick(); tick();
        sdif.sd_ack = 1'b1; tick();
        reset_n = 1'b0; #2;
        req_rd = 2'b00;
        tick();
        reset_n = 1'b1;
        req_rd = 2'b01;
        seen_rd = '0; seen_bw = '0;
        for (int i = 0; i < 5; i++) begin
            sdif.sd_buff_wr = ~sdif.sd_buff_wr;
            #1;
            seen_bw |= req_buff_wr;
            tick();
            seen_rd |= sdif.sd_rd | sdif.sd_wr;
        end
        checks++; if (seen_rd !== 2'b00) begin errors++; $display("FAIL stale_grant: got %b want 00", seen_rd); end
        checks++; if (seen_bw !== 2'b00) begin errors++; $display("FAIL stale_buff_wr: got %b want 00", seen_bw); end
        sdif.sd_ack = 1'b0; sdif.sd_buff_wr = 1'b0;
        tick();
        checks++; if (sdif.sd_rd !== 2'b01) begin errors++; $display("FAIL stale_release: got %b want 01", sdif.sd_rd); end
        sdif.sd_ack = 1'b1; tick();
        sdif.sd_ack = 1'b0; tick(); tick();
        req_rd = 2'b00; tick();
    endtask

    task automatic test_mount();
        logic [1:0] seen;
        req_rd = 2'b01; tick(); req_rd = 2'b00; tick();
        sdif.sd_ack = 1'b1; tick();
        req_wr = 2'b10; tick(); req_wr = 2'b00;
        checks++; if (req_busy !== 2'b11) begin errors++; $display("FAIL mnt_busy_pre: got %b want 11", req_busy); end
        img_mounted = 2'b11; tick(); img_mounted = 2'b00;
        checks++; if (req_busy !== 2'b01) begin errors++; $display("FAIL mnt_busy_post: got %b want 01", req_busy); end
        sdif.sd_ack = 1'b0; tick();
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL mnt_done: got %b want 01", req_done); end
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= sdif.sd_rd | sdif.sd_wr;
        end
        checks++; if (seen !== 2'b00 || req_busy !== 2'b00) begin errors++; $display("FAIL mnt_no_grant: seen %b busy %b want 00/00", seen, req_busy); end
    endtask

`ifdef SD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic early;
        do_reset();
        req_rd = 2'b01; tick(); req_rd = 2'b00; tick();
        early = 1'b0;
        for (int i = 1; i < 100; i++) begin
            if (req_done !== 2'b00 || req_err !== 2'b00 || sdif.sd_rd !== 2'b01) early = 1'b1;
            tick();
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", early); end
        checks++; if (req_err !== 2'b01 || req_done !== 2'b01) begin errors++; $display("FAIL to_pulse: err %b done %b want 01/01", req_err, req_done); end
        tick();
        checks++; if (sdif.sd_rd !== 2'b00 || req_err !== 2'b00 || req_busy !== 2'b00) begin errors++; $display("FAIL to_after: rd %b err %b busy %b want 00/00/00", sdif.sd_rd, req_err, req_busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_steer();
        test_stale_ack();
        test_mount();
`ifdef SD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
- Shares the single hps_io SD sector interface (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*) between two floppy drive requesters, so drive 0 and drive 1 can both be mounted.
- Sits between hps_io and the tatung FDC image logic.
- Arbitrates round-robin, sequences one sector transaction at a time, and steers buffer traffic to the granted drive only.

Parameters:
- NREQ, 2, number of requesters (fixed at 2; sd_rd/sd_wr width).
- TIMEOUT_CYCLES, 24'd16000000, maximum cycles to wait for sd_ack rise (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock (32 MHz).
- reset_n  in  1  asynchronous active-low reset.
- req_lba  in  64  per-drive sector LBA, {drive1[31:0], drive0[31:0]}; held stable by requester until its req_done.
- req_rd  in  2  per-drive read request pulse/level; captured into pending on a 0->1 edge.
- req_wr  in  2  per-drive write request; captured on a 0->1 edge.
- req_busy  out  2  pending or in service, per drive.
- req_done  out  2  one-cycle completion pulse, per drive.
- req_err  out  2  one-cycle timeout pulse, coincident with req_done.
- req_buff_addr  out  9  broadcast copy of sd_buff_addr.
- req_buff_dout  out  8  broadcast copy of sd_buff_dout.
- req_buff_din  in  16  per-drive write data, {drive1, drive0}.
- req_buff_wr  out  2  sd_buff_wr steered to the granted drive.
- img_mounted  in  2  per-drive mount pulse; cancels that drive's pending request.
- sd_lba  out  32  to hps_io.
- sd_rd  out  2  to hps_io, bit g for drive g.
- sd_wr  out  2  to hps_io.
- sd_ack  in  1  from hps_io.
- sd_buff_addr  in  9  from hps_io.
- sd_buff_dout  in  8  from hps_io.
- sd_buff_din  out  8  to hps_io.
- sd_buff_wr  in  1  from hps_io.

Behaviour:
- Reset values (async on reset_n=0):
  - State IDLE; sd_rd=0, sd_wr=0, sd_lba=0.
  - req_done=0, req_err=0, pending=0.
  - last_grant=1, so drive 0 wins the first tie.
- Capture:
  - A rising edge of req_rd[i] sets pend_rd[i]; a rising edge of req_wr[i] sets pend_wr[i].
  - If both rise on the same cycle, read wins and the write is dropped.
  - An edge arriving while drive i is already pending or in service is ignored.
  - req_busy[i] = pend_rd[i] | pend_wr[i].
- img_mounted[i]=1 clears drive i's pending bits, unless drive i is the granted drive in REQ or XFER; the current transaction then completes normally.
- State machine:
  - IDLE: if any drive is pending and sd_ack=0, select g. If both are pending, g = ~last_grant; otherwise g is the single pending drive. Register sd_lba <= req_lba[g]. Go to REQ.
  - REQ: sd_rd[g] or sd_wr[g] is held high. On sd_ack=1, drop sd_rd/sd_wr next cycle and go to XFER.
  - XFER: wait for sd_ack=0, then go to DONE.
  - DONE: req_done[g]=1 for one cycle; clear pend_*[g]; last_grant <= g; go to IDLE.
- Latency: a request edge to sd_rd/sd_wr high takes 2 cycles (capture, then IDLE->REQ), given an idle bus. sd_ack fall to req_done takes 1 cycle.
- IDLE never grants while sd_ack=1. This covers a stale upstream transfer after a reset mid-operation.
- Data steering:
  - req_buff_wr[i] = sd_buff_wr & sd_ack & (state in REQ/XFER) & (g==i).
  - sd_buff_din = req_buff_din[g] (combinational mux); 0 when not REQ/XFER.
  - sd_buff_wr while IDLE is discarded.
- sd_rd and sd_wr are never both nonzero, and never have more than one bit set.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- With it: a 24-bit counter clears on entering REQ and increments each REQ cycle. Reaching TIMEOUT_CYCLES-1 forces sd_rd/sd_wr=0, pulses req_err[g] with req_done[g], clears pend_*[g], sets last_grant<=g, and returns to IDLE. XFER is not timed.
- Without it: req_err is tied to 0 and REQ waits indefinitely.

Decomposition:
- Package sd_arb_pkg holds:
  - the state enum {IDLE, REQ, XFER, DONE};
  - NREQ;
  - width constants LBA_W=32, ADDR_W=9, DATA_W=8.
- One sub-module, sd_arb_rr: the 2-way round-robin picker. Inputs: pending[1:0] and last_grant. Outputs: grant index and valid. Purely combinational.

Test Plan:
- Drive0 read edge, LBA 0x10 -> cycle+2: sd_lba=0x10, sd_rd=2'b01. sd_ack high 4 cycles with sd_buff_wr bursts -> req_buff_wr=2'b01 only. sd_ack low -> req_done=2'b01 one cycle later.
- Drive0 and drive1 write edges on the same cycle -> drive0 served first (sd_wr=01), then drive1 (sd_wr=10). Repeat with both pending again -> drive1 served first.
- Drive1 write with req_buff_din[15:8]=0xA5 during XFER -> sd_buff_din=0xA5, and drive0 data never appears on sd_buff_din.
- Assert reset_n=0 mid-XFER with sd_ack held high, release, then issue a drive0 request -> no grant until sd_ack=0, and no req_buff_wr during the stale ack.
- img_mounted[1] while drive1 is pending and drive0 is in XFER -> drive1 is never granted and req_busy[1]=0. Drive0 gets req_done normally.
- SD_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=100 and sd_ack held low -> sd_rd drops, and req_err and req_done pulse together at REQ cycle 100.
